// File: rtl/cpu_defs.sv
// cpu_defs: shared CPU types and constants for the CP0/TLB interface
package cpu_defs;

   typedef enum logic [1:0] {TLB_WI, TLB_WR, TLB_R, TLB_P} tlb_op_t;
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} tlb_state_t;

   localparam logic [2:0]  KSEG0      = 3'b100;
   localparam logic [2:0]  KSEG1      = 3'b101;
   localparam logic [31:0] UNMAP_MASK = 32'h1FFF_FFFF;
   localparam logic [2:0]  C_UNCACHED = 3'd2;

   typedef struct packed {
      logic [31:0] index;
      logic [31:0] random;
      logic [31:0] entryhi;
      logic [31:0] pagemask;
      logic [31:0] entrylo0;
      logic [31:0] entrylo1;
   } tlb_t;

   // pfn is sized for the widest supported physical address (PABITS <= 32)
   typedef struct packed {
      logic [19:0] pfn;
      logic [2:0]  c;
      logic        d;
      logic        v;
   } tlb_half_t;

   typedef struct packed {
      logic [18:0] vpn2;
      logic [7:0]  asid;
      logic        g;
      tlb_half_t   lo0;
      tlb_half_t   lo1;
   } tlb_entry_t;

   function automatic logic unmapped(input logic [31:0] va);
      return va[31:29] == KSEG0 || va[31:29] == KSEG1;
   endfunction

endpackage

// File: rtl/tlb_lookup.sv
// tlb_lookup: associative tag match with lowest-index-wins priority encoding
module tlb_lookup
   import cpu_defs::*;
#(
   parameter int N  = 32,
   parameter int IW = 5
) (
   input  logic [N-1:0][27:0] tags,
   input  logic [18:0]        vpn2,
   input  logic [7:0]         asid,
   output logic               hit,
   output logic [IW-1:0]      idx
);

   // tag layout: {vpn2[18:0], asid[7:0], g}
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--)
         if (tags[i][27:9] == vpn2 && (tags[i][0] || tags[i][8:1] == asid)) begin
            hit = 1'b1;
            idx = IW'(i);
         end
   end

endmodule

// File: rtl/tlb_unit.sv
// tlb_unit: joint MIPS32 TLB (4 KB pages) with CP0 maintenance ops and
// registered instruction/data translation including kseg0/kseg1 bypass
module tlb_unit
   import cpu_defs::*;
#(
   parameter int INDEX_WIDTH = 5,
   parameter int PABITS      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  tlb_op_t           op,
   input  tlb_t              write_tlb,
   output logic              ready,
   output tlb_t              read_tlb,
   input  logic              hold,
   input  logic [31:0]       i_vaddr,
   output logic [PABITS-1:0] i_paddr,
   output logic              i_miss,
   output logic              i_invalid,
   output logic              i_uncached,
   input  logic [31:0]       d_vaddr,
   input  logic              d_we,
   output logic [PABITS-1:0] d_paddr,
   output logic              d_miss,
   output logic              d_invalid,
   output logic              d_modified,
   output logic              d_uncached
);

   localparam int TLB_SIZE = 2 ** INDEX_WIDTH;
   localparam int PW       = PABITS - 12;

   tlb_state_t                      state, next;
   tlb_op_t                         op_q;
   tlb_entry_t [TLB_SIZE-1:0]       entries;
   logic       [TLB_SIZE-1:0][27:0] tags;
   tlb_entry_t                      new_e, re, ie, de;
   tlb_half_t                       ih, dh;
   logic                            i_hit, d_hit, p_hit_c, p_hit;
   logic [INDEX_WIDTH-1:0]          i_idx, d_idx, p_idx_c, p_idx, w_idx, r_idx;
   logic                            i_um, d_um;
   logic                            unused;

   assign unused = ^{write_tlb.index[31:INDEX_WIDTH], write_tlb.random[31:INDEX_WIDTH],
                     write_tlb.entryhi[12:8], write_tlb.pagemask,
                     write_tlb.entrylo0[31:PABITS-6], write_tlb.entrylo1[31:PABITS-6]};

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ST_IDLE;
      else     state <= next;

   always_comb begin
      next  = state == ST_IDLE ? (req ? ST_EXEC : ST_IDLE) :
              state == ST_EXEC ? ST_DONE : ST_IDLE;
      ready = state == ST_DONE || !req;
   end

   always_comb begin
      w_idx          = write_tlb.index[INDEX_WIDTH-1:0];
      r_idx          = write_tlb.random[INDEX_WIDTH-1:0];
      new_e.vpn2     = write_tlb.entryhi[31:13];
      new_e.asid     = write_tlb.entryhi[7:0];
      new_e.g        = write_tlb.entrylo0[0] & write_tlb.entrylo1[0];
      new_e.lo0.pfn  = 20'(write_tlb.entrylo0[PABITS-7:6]);
      new_e.lo0.c    = write_tlb.entrylo0[5:3];
      new_e.lo0.d    = write_tlb.entrylo0[2];
      new_e.lo0.v    = write_tlb.entrylo0[1];
      new_e.lo1.pfn  = 20'(write_tlb.entrylo1[PABITS-7:6]);
      new_e.lo1.c    = write_tlb.entrylo1[5:3];
      new_e.lo1.d    = write_tlb.entrylo1[2];
      new_e.lo1.v    = write_tlb.entrylo1[1];
      re             = entries[w_idx];
      ie             = entries[i_idx];
      de             = entries[d_idx];
      ih             = i_vaddr[12] ? ie.lo1 : ie.lo0;
      dh             = d_vaddr[12] ? de.lo1 : de.lo0;
      i_um           = unmapped(i_vaddr);
      d_um           = unmapped(d_vaddr);
      for (int k = 0; k < TLB_SIZE; k++) tags[k] = {entries[k].vpn2, entries[k].asid, entries[k].g};
   end

   tlb_lookup #(.N(TLB_SIZE), .IW(INDEX_WIDTH)) u_i_lookup (
      .tags(tags), .vpn2(i_vaddr[31:13]), .asid(write_tlb.entryhi[7:0]), .hit(i_hit), .idx(i_idx)
   );

   tlb_lookup #(.N(TLB_SIZE), .IW(INDEX_WIDTH)) u_d_lookup (
      .tags(tags), .vpn2(d_vaddr[31:13]), .asid(write_tlb.entryhi[7:0]), .hit(d_hit), .idx(d_idx)
   );

   tlb_lookup #(.N(TLB_SIZE), .IW(INDEX_WIDTH)) u_p_lookup (
      .tags(tags), .vpn2(write_tlb.entryhi[31:13]), .asid(write_tlb.entryhi[7:0]),
      .hit(p_hit_c), .idx(p_idx_c)
   );

   // writes land on the EXEC edge, so a lookup sampled on that same edge still sees old contents
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         entries  <= '0;
         op_q     <= TLB_WI;
         p_hit    <= 1'b0;
         p_idx    <= '0;
         read_tlb <= '0;
      end else begin
         if (state == ST_IDLE && req) op_q <= op;
         if (state == ST_EXEC && op_q == TLB_WI) entries[w_idx] <= new_e;
         if (state == ST_EXEC && op_q == TLB_WR) entries[r_idx] <= new_e;
         if (state == ST_EXEC && op_q == TLB_R) begin
            read_tlb.entryhi  <= {re.vpn2, 5'b0, re.asid};
            read_tlb.pagemask <= '0;
            read_tlb.entrylo0 <= 32'({re.lo0.pfn[PW-1:0], re.lo0.c, re.lo0.d, re.lo0.v, re.g});
            read_tlb.entrylo1 <= 32'({re.lo1.pfn[PW-1:0], re.lo1.c, re.lo1.d, re.lo1.v, re.g});
         end
         if (state == ST_EXEC && op_q == TLB_P) begin
            p_hit <= p_hit_c;
            p_idx <= p_idx_c;
         end
         if (state == ST_DONE && op_q == TLB_P) read_tlb.index <= {!p_hit, 31'(p_idx)};
      end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         i_paddr    <= '0;
         i_miss     <= 1'b0;
         i_invalid  <= 1'b0;
         i_uncached <= 1'b0;
         d_paddr    <= '0;
         d_miss     <= 1'b0;
         d_invalid  <= 1'b0;
         d_modified <= 1'b0;
         d_uncached <= 1'b0;
      end else if (!hold) begin
         i_paddr    <= i_um ? PABITS'(i_vaddr & UNMAP_MASK) : {ih.pfn[PW-1:0], i_vaddr[11:0]};
         i_miss     <= !i_um && !i_hit;
         i_invalid  <= !i_um && i_hit && !ih.v;
         i_uncached <= i_um ? i_vaddr[31:29] == KSEG1 : i_hit && ih.v && ih.c == C_UNCACHED;
         d_paddr    <= d_um ? PABITS'(d_vaddr & UNMAP_MASK) : {dh.pfn[PW-1:0], d_vaddr[11:0]};
         d_miss     <= !d_um && !d_hit;
         d_invalid  <= !d_um && d_hit && !dh.v;
         d_modified <= !d_um && d_hit && dh.v && d_we && !dh.d;
         d_uncached <= d_um ? d_vaddr[31:29] == KSEG1 : d_hit && dh.v && dh.c == C_UNCACHED;
      end

endmodule
